dmac_bus_arbiter: RTL

//  Shares the single DMAC AHB master port among NUM_CH DMA channels. Picks a requesting

---
 rtl/dmac_pkg.sv | 20 ++
 rtl/dmac_rr_pick.sv | 40 ++++
 rtl/dmac_bus_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/dmac_pkg.sv
// Shared types and helpers for the DMAC bus arbiter.
//   arb_state_e : arbiter FSM states
//   DMAC_NUM_CH : default channel count
//   ch_id_w()   : width of a channel index for n channels (min 1)
package dmac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSREQ  = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int DMAC_NUM_CH = 4;

  function automatic int ch_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmac_rr_pick.sv
// Combinational round-robin picker.
//   req    : per-channel request vector
//   ptr    : last winner; scan starts at ptr+1 (mod NUM_CH)
//   onehot : one-hot winner (0 if none)
//   idx    : index of winner (0 if none)
//   any    : at least one request present
module dmac_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_CH-1:0] onehot,
  output logic [ID_W-1:0]   idx,
  output logic              any
);

  int            j;
  logic [ID_W-1:0] jj;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    jj     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      // wrap without a modulo so non-power-of-two channel counts work
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      jj = ID_W'(j);
      if (!any && req[jj]) begin
        any        = 1'b1;
        idx        = jj;
        onehot[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmac_bus_arbiter.sv
// Shares the DMAC AHB master port among NUM_CH channels.
// Round-robin pick in IDLE, bus request/grant handshake, owns the bus for the
// channel's programmed burst (beats-1 counter), then releases for one cycle.
//   hclk/hrst_n     : clock, synchronous active-low reset
//   arb_en          : enables new picks in IDLE
//   ch_req/ch_len   : per-channel request level and beats-1
//   ch_gnt/ch_id    : owning channel (one-hot) / selected channel index
//   ch_done         : 1-cycle pulse after a channel's last beat
//   xfer_start      : 1-cycle pulse on every entry to OWN
//   beat_done       : one data beat accepted by the master engine
//   m_hbusreq/m_hlock/m_hgrant/m_hready : AHB master arbitration signals
module dmac_bus_arbiter
  import dmac_pkg::*;
#(
  parameter int NUM_CH  = DMAC_NUM_CH,
  parameter int LEN_W   = 8,
  parameter int LOCK_EN = 0
) (
  input  logic                    hclk,
  input  logic                    hrst_n,
  input  logic                    arb_en,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH*LEN_W-1:0] ch_len,
  output logic [NUM_CH-1:0]       ch_gnt,
  output logic [ch_id_w(NUM_CH)-1:0] ch_id,
  output logic [NUM_CH-1:0]       ch_done,
  output logic                    xfer_start,
  input  logic                    beat_done,
  output logic                    m_hbusreq,
  output logic                    m_hlock,
  input  logic                    m_hgrant,
  input  logic                    m_hready
);

  localparam int   ID_W   = ch_id_w(NUM_CH);
  localparam logic LOCK_B = (LOCK_EN != 0);

  arb_state_e                     state;
  logic [ID_W-1:0]                ptr;
  logic [LEN_W-1:0]               cnt;
  logic [NUM_CH-1:0]              sel_oh;
  logic [NUM_CH-1:0][LEN_W-1:0]   len_arr;
  logic [NUM_CH-1:0]              pick_oh;
  logic [ID_W-1:0]                pick_idx;
  logic                           pick_any;

  assign len_arr = ch_len;

  dmac_rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick (
    .req    (ch_req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge hclk) begin
    if (!hrst_n) begin
      state      <= IDLE;
      ptr        <= ID_W'(NUM_CH - 1);
      cnt        <= '0;
      sel_oh     <= '0;
      ch_gnt     <= '0;
      ch_id      <= '0;
      ch_done    <= '0;
      xfer_start <= 1'b0;
      m_hbusreq  <= 1'b0;
      m_hlock    <= 1'b0;
    end else begin
      xfer_start <= 1'b0;
      ch_done    <= '0;
      case (state)
        IDLE: begin
          if (arb_en && pick_any) begin
            state     <= BUSREQ;
            ch_id     <= pick_idx;
            ptr       <= pick_idx;
            sel_oh    <= pick_oh;
            cnt       <= len_arr[pick_idx];
            m_hbusreq <= 1'b1;
            m_hlock   <= LOCK_B;
          end
        end
        BUSREQ: begin
          if (m_hgrant && m_hready) begin
            state      <= OWN;
            ch_gnt     <= sel_oh;
            xfer_start <= 1'b1;
          end
        end
        OWN: begin
          if (beat_done && cnt == '0) begin
            state     <= RELEASE;
            ch_done   <= sel_oh;
            ch_gnt    <= '0;
            m_hbusreq <= 1'b0;
            m_hlock   <= 1'b0;
          end else begin
            if (beat_done) cnt <= cnt - 1'b1;
            // preempted by the system arbiter: keep cnt, re-request for the same channel
            if (!m_hgrant && m_hready) begin
              state  <= BUSREQ;
              ch_gnt <= '0;
            end
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
